// File: rtl/fpu_req_ctrl.sv
// fpu_req_ctrl: issuing side of the FPU command interface.
//
// Accepts one operation at a time from the host request port and drives the FPU
// (fpu_cmd/fpu_din1/fpu_din2 with a one-cycle fpu_dval pulse). It holds the command and
// operands until the FPU reports fpu_rdy, then returns the captured result on the response
// port. Illegal commands are answered locally without touching the FPU.
//
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   req_valid/req_ready          host request handshake
//   req_cmd, req_op1, req_op2    1 = add, 2 = mul, 3 = div; all other codes are illegal
//   resp_valid/resp_ready        host response handshake
//   resp_data, resp_err          result (0 on illegal cmd, 7FC00000 on timeout), error flag
//   busy                         controller not idle
//   fpu_cmd, fpu_din1, fpu_din2  command/operands to the FPU
//   fpu_dval                     one-cycle start pulse to the FPU
//   fpu_result, fpu_rdy          result and ready from the FPU
//
// Parameters:
//   RDY_MASK_CYC  WAIT cycles after the fpu_dval pulse during which fpu_rdy is ignored (>= 1)
//   TIMEOUT_CYC   WAIT cycle limit before a forced error response
//
// Build option:
//   FPU_REQ_TIMEOUT_EN  when defined, enables the WAIT-state timeout counter.
//                       When undefined, WAIT lasts until a qualified fpu_rdy.

module fpu_req_ctrl #(
  parameter int unsigned RDY_MASK_CYC = 1,
  parameter int unsigned TIMEOUT_CYC  = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [3:0]  req_cmd,
  input  logic [31:0] req_op1,
  input  logic [31:0] req_op2,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_data,
  output logic        resp_err,
  output logic        busy,
  output logic [3:0]  fpu_cmd,
  output logic [31:0] fpu_din1,
  output logic [31:0] fpu_din2,
  output logic        fpu_dval,
  input  logic [31:0] fpu_result,
  input  logic        fpu_rdy
);

  localparam logic [1:0] StIdle  = 2'd0;
  localparam logic [1:0] StIssue = 2'd1;
  localparam logic [1:0] StWait  = 2'd2;
  localparam logic [1:0] StResp  = 2'd3;

  localparam logic [3:0] CmdAdd = 4'h1;
  localparam logic [3:0] CmdMul = 4'h2;
  localparam logic [3:0] CmdDiv = 4'h3;

  localparam logic [31:0] TimeoutData = 32'h7FC0_0000;

  localparam int unsigned      MaskW    = $clog2(RDY_MASK_CYC + 1);
  localparam logic [MaskW-1:0] MaskInit = MaskW'(RDY_MASK_CYC);

  logic [1:0]       state_q, state_d;
  logic [MaskW-1:0] mask_q, mask_d;
  logic [3:0]       cmd_q, cmd_d;
  logic [31:0]      din1_q, din1_d;
  logic [31:0]      din2_q, din2_d;
  logic             dval_q, dval_d;
  logic             resp_valid_q, resp_valid_d;
  logic [31:0]      resp_data_q, resp_data_d;
  logic             resp_err_q, resp_err_d;
  logic             cmd_legal;
  logic             rdy_qual;

`ifdef FPU_REQ_TIMEOUT_EN
  localparam int unsigned     TmoW   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TmoW-1:0] TmoMax = TmoW'(TIMEOUT_CYC);

  logic [TmoW-1:0] tmo_q, tmo_d;
`endif

  assign cmd_legal = (req_cmd == CmdAdd) || (req_cmd == CmdMul) || (req_cmd == CmdDiv);

  always_comb begin
    state_d      = state_q;
    mask_d       = mask_q;
    cmd_d        = cmd_q;
    din1_d       = din1_q;
    din2_d       = din2_q;
    dval_d       = 1'b0;
    resp_valid_d = resp_valid_q;
    resp_data_d  = resp_data_q;
    resp_err_d   = resp_err_q;
    rdy_qual     = 1'b0;
`ifdef FPU_REQ_TIMEOUT_EN
    tmo_d        = tmo_q;
`endif

    case (state_q)
      StIdle: begin
        if (req_valid) begin
          if (cmd_legal) begin
            cmd_d   = req_cmd;
            din1_d  = req_op1;
            din2_d  = req_op2;
            // Registered so the pulse lines up exactly with the ISSUE cycle.
            dval_d  = 1'b1;
            state_d = StIssue;
          end else begin
            resp_data_d  = 32'h0;
            resp_err_d   = 1'b1;
            resp_valid_d = 1'b1;
            state_d      = StResp;
          end
        end
      end

      StIssue: begin
        mask_d  = MaskInit;
`ifdef FPU_REQ_TIMEOUT_EN
        tmo_d   = '0;
`endif
        state_d = StWait;
      end

      StWait: begin
        // A rdy seen right after the pulse may be left over from the previous operation.
        rdy_qual = (mask_q == '0) && fpu_rdy;
        if (mask_q != '0) begin
          mask_d = mask_q - MaskW'(1);
        end
        if (rdy_qual) begin
          resp_data_d  = fpu_result;
          resp_err_d   = 1'b0;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end
`ifdef FPU_REQ_TIMEOUT_EN
        else if (tmo_q == TmoMax) begin
          resp_data_d  = TimeoutData;
          resp_err_d   = 1'b1;
          resp_valid_d = 1'b1;
          state_d      = StResp;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
`endif
      end

      StResp: begin
        if (resp_ready) begin
          resp_valid_d = 1'b0;
          // The FPU muxes rdy/result by cmd, so operands are only dropped once the host has
          // taken the response.
          cmd_d        = 4'h0;
          din1_d       = 32'h0;
          din2_d       = 32'h0;
          state_d      = StIdle;
        end
      end

      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= StIdle;
      mask_q       <= '0;
      cmd_q        <= 4'h0;
      din1_q       <= 32'h0;
      din2_q       <= 32'h0;
      dval_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      resp_data_q  <= 32'h0;
      resp_err_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      mask_q       <= mask_d;
      cmd_q        <= cmd_d;
      din1_q       <= din1_d;
      din2_q       <= din2_d;
      dval_q       <= dval_d;
      resp_valid_q <= resp_valid_d;
      resp_data_q  <= resp_data_d;
      resp_err_q   <= resp_err_d;
    end
  end

`ifdef FPU_REQ_TIMEOUT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= '0;
    end else begin
      tmo_q <= tmo_d;
    end
  end
`endif

  assign req_ready  = (state_q == StIdle);
  assign busy       = (state_q != StIdle);
  assign resp_valid = resp_valid_q;
  assign resp_data  = resp_data_q;
  assign resp_err   = resp_err_q;
  assign fpu_cmd    = cmd_q;
  assign fpu_din1   = din1_q;
  assign fpu_din2   = din2_q;
  assign fpu_dval   = dval_q;

endmodule

// File: tb/tb_fpu_req_ctrl.sv
// Testbench for fpu_req_ctrl: table-driven operations against a stub FPU, plus hand-written
// reset and reset-in-WAIT sequences. The DUT is built with a two-cycle rdy mask.

module tb_fpu_req_ctrl;

  localparam int unsigned MaskCyc = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [3:0]  req_cmd = 4'h0;
  logic [31:0] req_op1 = 32'h0;
  logic [31:0] req_op2 = 32'h0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        busy;
  logic [3:0]  fpu_cmd;
  logic [31:0] fpu_din1;
  logic [31:0] fpu_din2;
  logic        fpu_dval;
  logic [31:0] fpu_result;
  logic        fpu_rdy;

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  fpu_req_ctrl #(
    .RDY_MASK_CYC (MaskCyc),
    .TIMEOUT_CYC  (64)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_cmd    (req_cmd),
    .req_op1    (req_op1),
    .req_op2    (req_op2),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .busy       (busy),
    .fpu_cmd    (fpu_cmd),
    .fpu_din1   (fpu_din1),
    .fpu_din2   (fpu_din2),
    .fpu_dval   (fpu_dval),
    .fpu_result (fpu_result),
    .fpu_rdy    (fpu_rdy)
  );

  // Stub FPU: raises rdy stub_lat cycles after the cycle following fpu_dval, or always.
  logic        stub_act;
  int unsigned stub_cnt;
  int unsigned stub_lat = 0;
  logic        stub_always = 1'b0;
  logic [31:0] stub_res = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stub_act <= 1'b0;
      stub_cnt <= 0;
    end else if (fpu_dval) begin
      stub_act <= 1'b1;
      stub_cnt <= 0;
    end else if (resp_valid) begin
      stub_act <= 1'b0;
    end else if (stub_act) begin
      stub_cnt <= stub_cnt + 1;
    end
  end

  assign fpu_rdy    = stub_always | (stub_act && (stub_cnt >= stub_lat));
  assign fpu_result = stub_res;

  typedef struct {
    logic [3:0]  cmd;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] res;
    int unsigned lat;
    logic        always_rdy;
    int unsigned hold;
    logic [31:0] exp_data;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [3:0] cmd, input logic [31:0] op1,
                              input logic [31:0] op2, input logic [31:0] res,
                              input int unsigned lat, input logic always_rdy,
                              input int unsigned hold, input logic [31:0] exp_data,
                              input logic exp_err, input int exp_lat);
    vec_t v;
    v.cmd = cmd; v.op1 = op1; v.op2 = op2; v.res = res; v.lat = lat;
    v.always_rdy = always_rdy; v.hold = hold; v.exp_data = exp_data;
    v.exp_err = exp_err; v.exp_lat = exp_lat;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end else begin
      n_pass++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    logic        legal;
    logic [3:0]  e_cmd;
    logic [31:0] e_op1, e_op2;
    logic [31:0] held_d;
    logic        held_e;
    int t, dval_n, lat, bad, bad2;
    bit seen;
    legal = (v.cmd == 4'h1) || (v.cmd == 4'h2) || (v.cmd == 4'h3);
    e_cmd = legal ? v.cmd : 4'h0;
    e_op1 = legal ? v.op1 : 32'h0;
    e_op2 = legal ? v.op2 : 32'h0;

    @(negedge clk);
    check("idle_req_ready", {31'h0, req_ready}, 32'h1);
    stub_lat = v.lat; stub_always = v.always_rdy; stub_res = v.res;
    req_valid = 1'b1; req_cmd = v.cmd; req_op1 = v.op1; req_op2 = v.op2;
    t = 0; dval_n = 0; lat = 0; bad = 0; seen = 0;
    while (!seen && t < 200) begin
      @(negedge clk);
      t++;
      // A different request stays valid for the whole operation and must be ignored.
      req_cmd = 4'h1; req_op1 = 32'hDEAD_BEEF; req_op2 = 32'h0BAD_F00D;
      if (fpu_dval) dval_n++;
      if (fpu_cmd !== e_cmd || fpu_din1 !== e_op1 || fpu_din2 !== e_op2) bad++;
      if (resp_valid) begin
        seen = 1;
        lat  = t;
      end
    end
    check("resp_latency", lat, v.exp_lat);
    check("dval_pulses", dval_n, legal ? 1 : 0);
    check("resp_data", resp_data, v.exp_data);
    check("resp_err", {31'h0, resp_err}, {31'h0, v.exp_err});
    check("fpu_ops_stable", bad, 0);
    check("resp_req_ready", {31'h0, req_ready}, 32'h0);

    held_d = resp_data; held_e = resp_err; bad2 = 0;
    for (int i = 0; i < int'(v.hold); i++) begin
      @(negedge clk);
      if (!resp_valid || resp_data !== held_d || resp_err !== held_e || req_ready || fpu_dval)
        bad2++;
    end
    check("resp_hold", bad2, 0);

    resp_ready = 1'b1;
    @(negedge clk);
    check("post_resp_valid", {31'h0, resp_valid}, 32'h0);
    check("post_req_ready", {31'h0, req_ready}, 32'h1);
    check("post_busy", {31'h0, busy}, 32'h0);
    check("post_fpu_cmd", {28'h0, fpu_cmd}, 32'h0);
    req_valid = 1'b0; resp_ready = 1'b0; stub_always = 1'b0;
  endtask

  initial begin
    int ev;
    vecs.push_back(mk(4'h1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0, 1'b0, 0,
                      32'h4040_0000, 1'b0, 5));
    vecs.push_back(mk(4'h2, 32'h4000_0000, 32'h4040_0000, 32'h40C0_0000, 4, 1'b0, 3,
                      32'h40C0_0000, 1'b0, 7));
    vecs.push_back(mk(4'h3, 32'h40C0_0000, 32'h4000_0000, 32'h4040_0000, 0, 1'b1, 0,
                      32'h4040_0000, 1'b0, 5));
    vecs.push_back(mk(4'h5, 32'h1111_1111, 32'h2222_2222, 32'hFFFF_FFFF, 0, 1'b1, 10,
                      32'h0, 1'b1, 1));
    vecs.push_back(mk(4'h0, 32'h3333_3333, 32'h4444_4444, 32'hFFFF_FFFF, 0, 1'b0, 0,
                      32'h0, 1'b1, 1));
    vecs.push_back(mk(4'hF, 32'h5555_5555, 32'h6666_6666, 32'hFFFF_FFFF, 0, 1'b1, 2,
                      32'h0, 1'b1, 1));
    // rdy first rises exactly when the mask expires, then one cycle later.
    vecs.push_back(mk(4'h1, 32'h1234_5678, 32'h8765_4321, 32'h1357_9BDF, 2, 1'b0, 1,
                      32'h1357_9BDF, 1'b0, 5));
    vecs.push_back(mk(4'h2, 32'hCAFE_0001, 32'h0000_BEEF, 32'h2468_ACE0, 3, 1'b0, 0,
                      32'h2468_ACE0, 1'b0, 6));
`ifdef FPU_REQ_TIMEOUT_EN
    vecs.push_back(mk(4'h2, 32'h4000_0000, 32'h4000_0000, 32'h4080_0000, 1000, 1'b0, 0,
                      32'h7FC0_0000, 1'b1, 67));
`endif

    // Reset values while reset is held.
    #2;
    check("rst_ctrl", {28'h0, resp_valid, resp_err, fpu_dval, busy}, 32'h0);
    check("rst_data", resp_data | fpu_din1 | fpu_din2 | {28'h0, fpu_cmd}, 32'h0);
    check("rst_req_ready", {31'h0, req_ready}, 32'h1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    foreach (vecs[i]) run_vec(vecs[i]);

    // Reset while waiting on the FPU aborts the operation with no response.
    @(negedge clk);
    stub_lat = 50; stub_always = 1'b0; stub_res = 32'hABCD_EF01;
    req_valid = 1'b1; req_cmd = 4'h1; req_op1 = 32'h3F80_0000; req_op2 = 32'h3F80_0000;
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("wait_busy", {31'h0, busy}, 32'h1);
    check("wait_fpu_cmd", {28'h0, fpu_cmd}, 32'h1);
    rst_n = 1'b0;
    #1;
    check("abort_ctrl", {28'h0, resp_valid, resp_err, fpu_dval, busy}, 32'h0);
    check("abort_data", resp_data | fpu_din1 | fpu_din2 | {28'h0, fpu_cmd}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("abort_req_ready", {31'h0, req_ready}, 32'h1);
    ev = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (resp_valid || fpu_dval || busy) ev++;
    end
    check("abort_no_resp", ev, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
